// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and constants for the switch capture stage
// Purpose: FSM state type, debounce length defaults and the sw-bit to A..D mapping.
// Ports: none (package).
package capture_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_t;

  // 10 ms at 50 MHz for hardware; benches use the short value.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;

  // sw bit positions feeding each held code output.
  localparam int IDX_A = 3;
  localparam int IDX_B = 2;
  localparam int IDX_C = 1;
  localparam int IDX_D = 0;

endpackage

// File: rtl/switch_capture_if.sv
// rtl/switch_capture_if.sv - switch/button inputs and held-code outputs of the capture stage
// Purpose: groups the raw user inputs and the held code handed to the converter.
// Ports: sw[3:0], load_btn, clear (towards capture); A, B, C, D, ready, busy (from capture).
// Modports: master = stimulus/consumer side, slave = capture stage.
interface switch_capture_if;
  logic [3:0] sw;
  logic       load_btn;
  logic       clear;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       ready;
  logic       busy;

  modport master (
    output sw, load_btn, clear,
    input  A, B, C, D, ready, busy
  );

  modport slave (
    input  sw, load_btn, clear,
    output A, B, C, D, ready, busy
  );
endinterface

// File: rtl/switch_capture_debounce.sv
// rtl/switch_capture_debounce.sv - synchronizer and button debouncer
// Purpose: brings sw and load_btn into the clk domain and debounces the button.
// Ports: clk, reset (async, active-high), sw[3:0], load_btn in;
//        sw_s[3:0] (synchronized switches), busy (timing a transition),
//        press (one-cycle pulse on each debounced rising edge) out.
module debounce
  import capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       load_btn,
  output logic [3:0] sw_s,
  output logic       busy,
  output logic       press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] btn_sync;
  logic [3:0]             sw_sync [SYNC_STAGES];
  logic [CNT_W-1:0]       count;
  logic                   btn_s;
  logic                   btn_db;
  logic                   btn_db_q;

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      btn_sync   <= {btn_sync[SYNC_STAGES-2:0], load_btn};
      sw_sync[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  // Counter measures the run of samples disagreeing with btn_db; any
  // agreeing sample restarts it, so it never passes LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        count <= '0;
      end else if (count == LAST) begin
        btn_db <= btn_s;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign busy  = (count != '0);
  assign press = btn_db & ~btn_db_q;

endmodule

// File: rtl/switch_capture.sv
// rtl/switch_capture.sv - latches the switch code on each clean button press
// Purpose: holds A..D and ready for the code converter; clear drops ready.
// Ports: clk, reset (async assert, active-high), bus (switch_capture_if.slave:
//        sw, load_btn, clear in; A, B, C, D, ready, busy out).
module switch_capture
  import capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 24
) (
  input  logic              clk,
  input  logic              reset,
  switch_capture_if.slave   bus
);

  logic [3:0] sw_s;
  logic       busy;
  logic       press;
  state_t     state;
  logic [3:0] code;
  logic       ready_r;

  debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .sw       (bus.sw),
    .load_btn (bus.load_btn),
    .sw_s     (sw_s),
    .busy     (busy),
    .press    (press)
  );

  // clear has priority over press; A..D keep their value when leaving VALID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      code    <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (!bus.clear && press) begin
            code    <= sw_s;
            state   <= VALID;
            ready_r <= 1'b1;
          end
        end
        VALID: begin
          if (bus.clear) begin
            state   <= EMPTY;
            ready_r <= 1'b0;
          end else if (press) begin
            code <= sw_s;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A     = code[IDX_A];
  assign bus.B     = code[IDX_B];
  assign bus.C     = code[IDX_C];
  assign bus.D     = code[IDX_D];
  assign bus.ready = ready_r;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_switch_capture.sv
// tb/tb_switch_capture.sv - self-checking bench for switch_capture
module tb_switch_capture;
  import capture_pkg::*;

  localparam int DC = SIM_DEBOUNCE_CYCLES;
  localparam int S  = 2;
  localparam int HN = 4096;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  switch_capture_if bus ();

  switch_capture #(
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (S),
    .CNT_W           (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: btn_s is the raw button delayed S edges; btn_db flips once the
  // last DC samples all disagree with it; a press is its rising edge.
  logic       in_btn [HN];
  logic [3:0] in_sw  [HN];
  logic       bs_h   [HN];
  int         n      = 0;
  logic       m_db   = 1'b0;
  logic       m_db_q = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_busy = 1'b0;
  logic [3:0] m_code = 4'b0;
  int         m_caps = 0;

  always @(posedge clk or posedge reset) begin : model
    logic       bs;
    logic [3:0] ss;
    logic       pr;
    bit         flip;
    if (reset) begin
      n       = 0;
      m_db    = 1'b0;
      m_db_q  = 1'b0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_code  = 4'b0;
    end else begin
      in_btn[n] = bus.load_btn;
      in_sw[n]  = bus.sw;
      bs = (n >= S) ? in_btn[n-S] : 1'b0;
      ss = (n >= S) ? in_sw[n-S]  : 4'b0;
      bs_h[n] = bs;
      pr = m_db & ~m_db_q;
      flip = (n >= DC - 1);
      for (int j = 0; j < DC; j++)
        if (n - j >= 0 && bs_h[n-j] == m_db) flip = 0;
      m_db_q = m_db;
      if (flip) m_db = ~m_db;
      m_busy = (bs != m_db);
      if (bus.clear) m_valid = 1'b0;
      else if (pr) begin
        m_code  = ss;
        m_valid = 1'b1;
        m_caps++;
      end
      if (n < HN - 1) n++;
    end
  end

  always @(negedge clk) begin
    check("code", {bus.A, bus.B, bus.C, bus.D}, m_code);
    check("ready", bus.ready, m_valid);
    check("busy", bus.busy, m_busy);
  end

  function automatic logic [3:0] code_out();
    return {bus.A, bus.B, bus.C, bus.D};
  endfunction

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Holds load_btn high for k edges; returns the edge index where ready first
  // reads 1 and whether ready ever dropped.
  task automatic hold_press(input int k, output int first, output bit dropped);
    first = 0;
    dropped = 0;
    bus.load_btn = 1'b1;
    for (int i = 1; i <= k; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready && first == 0) first = i;
      if (!bus.ready) dropped = 1;
    end
  endtask

  initial begin : stim
    int  first;
    bit  dropped;
    bit  busy_seen;
    logic [4:0] pat;

    bus.sw = 4'b0;
    bus.load_btn = 1'b0;
    bus.clear = 1'b0;

    // Reset then idle
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(20);
    check("idle_code", code_out(), 4'b0000);
    check("idle_ready", bus.ready, 1'b0);
    check("idle_busy", bus.busy, 1'b0);

    // Clean press of 1011
    bus.sw = 4'b1011;
    hold_press(10, first, dropped);
    check("press1_latency", first, 7);
    bus.load_btn = 1'b0;
    wait_cycles(10);
    check("press1_code", code_out(), 4'b1011);
    check("press1_caps", m_caps, 1);

    // Switches change without a press, then recapture while valid
    bus.sw = 4'b0110;
    wait_cycles(10);
    check("hold_code", code_out(), 4'b1011);
    hold_press(10, first, dropped);
    check("recap_no_gap", dropped, 1'b0);
    bus.load_btn = 1'b0;
    wait_cycles(10);
    check("recap_code", code_out(), 4'b0110);
    check("recap_ready", bus.ready, 1'b1);
    check("recap_caps", m_caps, 2);

    // clear arrives in the press cycle: clear wins
    bus.sw = 4'b1111;
    bus.load_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) bus.clear = 1'b1;
      if (i == 7) begin
        bus.clear = 1'b0;
        check("clear_ready", bus.ready, 1'b0);
        check("clear_code", code_out(), 4'b0110);
      end
    end
    bus.load_btn = 1'b0;
    wait_cycles(10);
    check("clear_still_empty", bus.ready, 1'b0);
    check("clear_caps", m_caps, 2);

    // Bouncing button: 1,0,1,0,1 then held
    bus.sw = 4'b1001;
    pat = 5'b10101;
    first = 0;
    busy_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.load_btn = (i <= 5) ? pat[5-i] : 1'b1;
      @(posedge clk);
      #1;
      if (bus.ready && first == 0) first = i;
      if (bus.busy) busy_seen = 1;
    end
    check("bounce_latency", first, 11);
    check("bounce_busy_seen", busy_seen, 1'b1);
    check("bounce_code", code_out(), 4'b1001);
    check("bounce_caps", m_caps, 3);
    bus.load_btn = 1'b0;
    wait_cycles(10);

    // Async reset with the counter at 2
    bus.sw = 4'b0101;
    bus.load_btn = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_busy", bus.busy, 1'b1);
    check("pre_reset_ready", bus.ready, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset_outs", {bus.A, bus.B, bus.C, bus.D, bus.ready, bus.busy}, 6'b0);
    wait_cycles(2);
    reset = 1'b0;
    hold_press(10, first, dropped);
    check("post_reset_latency", first, 7);
    check("post_reset_code", code_out(), 4'b0101);
    check("post_reset_caps", m_caps, 4);
    bus.load_btn = 1'b0;
    wait_cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_capture.md
Name: switch_capture

Overview:
- Upstream input stage of the 4-bit code converter.
- Synchronizes the four data switches and a load push-button, and debounces the button.
- On each clean button press, latches the switch code onto A, B, C, D and asserts ready.
- The converter consumes A..D while ready=1. It drives its outputs to zero while ready=0.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced button changes level (10 ms at 50 MHz). Range 2..2^24-1.
- SYNC_STAGES, 2, flip-flop stages in the synchronizer for sw and load_btn. Minimum 2.
- CNT_W, 24, width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- sw  input  4  raw switches; sw[3]->A, sw[2]->B, sw[1]->C, sw[0]->D
- load_btn  input  1  raw load push-button, active-high, bouncing
- clear  input  1  synchronous clear of held code, active-high, already clean
- A  output  1  held code bit 3
- B  output  1  held code bit 2
- C  output  1  held code bit 1
- D  output  1  held code bit 0
- ready  output  1  held code valid
- busy  output  1  high while the debouncer is timing a candidate button transition

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - A=B=C=D=0, ready=0, busy=0.
  - Synchronizer flops cleared, debounced button=0, counter=0, FSM=EMPTY.
- Synchronizer:
  - sw and load_btn each pass through SYNC_STAGES flops, giving sw_s and btn_s.
  - Latency is SYNC_STAGES cycles.
- Debouncer:
  - Holds btn_db.
  - Each cycle btn_s==btn_db: counter<=0.
  - Each cycle btn_s!=btn_db: counter<=counter+1.
  - When the counter reaches DEBOUNCE_CYCLES-1 and btn_s!=btn_db: btn_db<=btn_s, counter<=0.
  - So btn_db toggles only after DEBOUNCE_CYCLES consecutive differing samples. Any glitch restarts timing.
  - busy = (counter!=0).
  - Counter never wraps; it is bounded by DEBOUNCE_CYCLES-1.
- Press event: press = btn_db & ~btn_db_q, a one-cycle pulse on the rising edge of btn_db.
- FSM states:
  - EMPTY: ready=0. press -> latch sw_s into A..D, go to VALID.
  - VALID: ready=1. press -> relatch sw_s; ready stays 1 with no low gap. clear -> go to EMPTY.
- Latency: the code latched is the sw_s value in the press cycle. A..D and ready update at the next clock edge.
- Outputs are registered, with no combinational path from any input.
- Switch changes without a press are ignored; A..D hold their value.
- clear in EMPTY: no effect.
- clear and press in the same cycle: clear wins. State becomes EMPTY, A..D keep their last value, the press is discarded.
- Holding the button: exactly one capture per press. A release must be debounced (btn_db falls) before another press can occur.
- Reset mid-debounce: all counter and debounce state is lost. After release, a button still held is seen as a new press only after SYNC_STAGES+DEBOUNCE_CYCLES cycles (btn_db starts at 0).
- A..D in EMPTY: retain the last captured code, but consumers must ignore them while ready=0.

Decomposition:
- Shared package capture_pkg:
  - FSM state enum: EMPTY, VALID.
  - Default DEBOUNCE_CYCLES constant and a SIM_DEBOUNCE_CYCLES=4 constant for benches.
  - Bit-index constants mapping sw bits to A..D.
- One natural sub-module: debounce. It contains the synchronizer, counter and btn_db, and outputs btn_db, busy and press.
- The FSM and capture register stay in switch_capture.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset then idle: reset=1 then 0, no inputs -> A..D=0000, ready=0, busy=0 for 20 cycles.
- Clean press: sw=1011, load_btn held high for 10 cycles.
  - ready rises exactly 2+4+1 cycles after load_btn rises.
  - A,B,C,D=1,0,1,1; one capture only.
- Bounce rejection: load_btn toggled 1,0,1,0,1 on successive cycles then held high.
  - No capture until 4 consecutive synced highs.
  - Exactly one capture; busy high during timing.
- Recapture while valid: after capture of 1011, set sw=0110 without a press -> A..D stay 1011.
  - Then press again -> A..D=0110, ready stays 1 every cycle.
- Clear vs press collision: in VALID, assert clear in the same cycle as the press pulse.
  - ready=0 the next cycle, A..D unchanged, no capture.
- Async reset mid-debounce: reset asserted with counter=2 -> all outputs 0 immediately.
  - Button held through release -> capture after 2+4+1 cycles.
